// File: rtl/revive_bus_arb_pkg.sv
// Shared AHB-lite constants and owner encoding for the ReVive bus arbiter.
package revive_bus_arb_pkg;
    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;
    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HPROT_BASE  = 3'b001;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;
endpackage

// File: rtl/revive_bus_arb.sv
// Two-requester (fetch / load-store) arbiter for the single AHB-lite master port,
// with address-phase hold across wait states and data-phase response routing.
module revive_bus_arb
    import revive_bus_arb_pkg::*;
#(
    parameter int W_ADDR       = 32,
    parameter int W_DATA       = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int STARVE_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ahblm_hready,
    input  logic              ahblm_hresp,
    input  logic [W_DATA-1:0] ahblm_hrdata,
    output logic [W_ADDR-1:0] ahblm_haddr,
    output logic              ahblm_hwrite,
    output logic [1:0]        ahblm_htrans,
    output logic [2:0]        ahblm_hsize,
    output logic [2:0]        ahblm_hburst,
    output logic [3:0]        ahblm_hprot,
    output logic              ahblm_hmastlock,
    output logic [W_DATA-1:0] ahblm_hwdata,
    input  logic              i_req,
    input  logic [W_ADDR-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rdy,
    output logic              i_err,
    output logic [W_DATA-1:0] i_rdata,
    input  logic              d_req,
    input  logic [W_ADDR-1:0] d_addr,
    input  logic              d_write,
    input  logic [2:0]        d_size,
    input  logic [W_DATA-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rdy,
    output logic              d_err,
    output logic [W_DATA-1:0] d_rdata
);
    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic                hold_valid_q, hold_valid_d;
    owner_e              hold_owner_q, hold_owner_d;
    logic                dph_valid_q, dph_valid_d;
    owner_e              dph_owner_q, dph_owner_d;
    logic                dph_write_q, dph_write_d;
    logic [W_DATA-1:0]   hwdata_q, hwdata_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

    logic   is_nseq;
    owner_e owner;
    logic   err_first;
    logic   i_force;

    assign err_first = dph_valid_q & ahblm_hresp & ~ahblm_hready;
    assign i_force   = (STARVE_LIMIT != 0) && (starve_cnt_q == LIMIT) && i_req;

    // Owner select: a held address phase beats priority; the first error
    // cycle idles the bus unless something is already held there.
    always_comb begin
        is_nseq = 1'b0;
        owner   = OWNER_I;
        if (!rst_n) begin
            is_nseq = 1'b0;
        end else if (hold_valid_q) begin
            is_nseq = 1'b1;
            owner   = hold_owner_q;
        end else if (!err_first) begin
            if (i_force) begin
                is_nseq = 1'b1;
                owner   = OWNER_I;
            end else if (d_req) begin
                is_nseq = 1'b1;
                owner   = OWNER_D;
            end else if (i_req) begin
                is_nseq = 1'b1;
                owner   = OWNER_I;
            end
        end
    end

    always_comb begin
        ahblm_htrans = HTRANS_IDLE;
        ahblm_haddr  = '0;
        ahblm_hsize  = HSIZE_BYTE;
        ahblm_hwrite = 1'b0;
        ahblm_hprot  = {HPROT_BASE, 1'b0};
        if (is_nseq) begin
            ahblm_htrans = HTRANS_NSEQ;
            if (owner == OWNER_D) begin
                ahblm_haddr  = d_addr;
                ahblm_hsize  = d_size;
                ahblm_hwrite = d_write;
                ahblm_hprot  = {HPROT_BASE, 1'b1};
            end else begin
                ahblm_haddr  = i_addr;
                ahblm_hsize  = HSIZE_WORD;
            end
        end
    end

    assign i_gnt = is_nseq & (owner == OWNER_I) & ahblm_hready;
    assign d_gnt = is_nseq & (owner == OWNER_D) & ahblm_hready;

    assign i_rdy   = dph_valid_q & (dph_owner_q == OWNER_I) & ahblm_hready;
    assign d_rdy   = dph_valid_q & (dph_owner_q == OWNER_D) & ahblm_hready;
    assign i_err   = i_rdy & ahblm_hresp;
    assign d_err   = d_rdy & ahblm_hresp;
    assign i_rdata = ahblm_hrdata;
    assign d_rdata = ahblm_hrdata;

    assign ahblm_hburst    = 3'b000;
    assign ahblm_hmastlock = 1'b0;
    assign ahblm_hwdata    = hwdata_q;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_owner_d = hold_owner_q;
        dph_valid_d  = dph_valid_q;
        dph_owner_d  = dph_owner_q;
        dph_write_d  = dph_write_q;
        hwdata_d     = hwdata_q;
        starve_cnt_d = starve_cnt_q;

        if (ahblm_hready) begin
            hold_valid_d = 1'b0;
            dph_valid_d  = is_nseq;
            dph_owner_d  = owner;
            dph_write_d  = ahblm_hwrite;
        end else if (is_nseq) begin
            hold_valid_d = 1'b1;
            hold_owner_d = owner;
        end

        if (d_gnt && d_write)
            hwdata_d = d_wdata;

        // Held cycles are not refusals: I is either on the bus or waiting on a
        // transfer that cannot be preempted anyway.
        if (i_gnt || !i_req)
            starve_cnt_d = '0;
        else if (!hold_valid_q && starve_cnt_q != LIMIT)
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_owner_q <= OWNER_I;
            dph_valid_q  <= 1'b0;
            dph_owner_q  <= OWNER_I;
            dph_write_q  <= 1'b0;
            hwdata_q     <= '0;
            starve_cnt_q <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_owner_q <= hold_owner_d;
            dph_valid_q  <= dph_valid_d;
            dph_owner_q  <= dph_owner_d;
            dph_write_q  <= dph_write_d;
            hwdata_q     <= hwdata_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end
endmodule

// File: tb/tb_revive_bus_arb.sv
// Directed bench for revive_bus_arb: reset, priority, hold, read return, error, starvation.
module tb_revive_bus_arb;
    logic        clk;
    logic        rst_n;
    logic        hready, hresp;
    logic [31:0] hrdata, haddr, hwdata;
    logic        hwrite, hmastlock;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic        i_req, i_gnt, i_rdy, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_write, d_gnt, d_rdy, d_err;
    logic [2:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rdata;

    int total = 0;
    int bad   = 0;

    revive_bus_arb dut (
        .clk(clk), .rst_n(rst_n),
        .ahblm_hready(hready), .ahblm_hresp(hresp), .ahblm_hrdata(hrdata),
        .ahblm_haddr(haddr), .ahblm_hwrite(hwrite), .ahblm_htrans(htrans),
        .ahblm_hsize(hsize), .ahblm_hburst(hburst), .ahblm_hprot(hprot),
        .ahblm_hmastlock(hmastlock), .ahblm_hwdata(hwdata),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rdy(i_rdy),
        .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_size(d_size),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rdy(d_rdy), .d_err(d_err),
        .d_rdata(d_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            i_req = 0; d_req = 0; d_write = 0; hready = 1; hresp = 0; hrdata = '0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0; i_req = 1; i_addr = 32'h40; d_req = 0; d_addr = 0; d_write = 0;
        d_size = 0; d_wdata = 0; hready = 1; hresp = 0; hrdata = 0;
        repeat (2) @(negedge clk);
        total++; if (htrans !== 2'b00) begin $display("FAIL rst_htrans got=%h exp=00", htrans); bad++; end
        total++; if (i_gnt !== 1'b0) begin $display("FAIL rst_i_gnt got=%b exp=0", i_gnt); bad++; end
        total++; if (haddr !== 32'h0) begin $display("FAIL rst_haddr got=%h exp=0", haddr); bad++; end
        total++; if (hwdata !== 32'h0) begin $display("FAIL rst_hwdata got=%h exp=0", hwdata); bad++; end
        total++; if ({i_rdy, d_rdy, d_gnt} !== 3'b000) begin $display("FAIL rst_rdy got=%b exp=000", {i_rdy, d_rdy, d_gnt}); bad++; end
        step(); rst_n = 1;
        @(negedge clk);
        total++; if (i_gnt !== 1'b1) begin $display("FAIL post_rst_i_gnt got=%b exp=1", i_gnt); bad++; end
        total++; if (haddr !== 32'h40) begin $display("FAIL post_rst_haddr got=%h exp=40", haddr); bad++; end
        total++; if (hprot !== 4'b0010) begin $display("FAIL post_rst_hprot got=%b exp=0010", hprot); bad++; end
        total++; if (hsize !== 3'd2) begin $display("FAIL post_rst_hsize got=%0d exp=2", hsize); bad++; end
        step(); i_req = 0;
        @(negedge clk);
        total++; if (i_rdy !== 1'b1) begin $display("FAIL post_rst_i_rdy got=%b exp=1", i_rdy); bad++; end
        idle(2);
    endtask

    task automatic test_simultaneous();
        step();
        i_req = 1; i_addr = 32'h200;
        d_req = 1; d_addr = 32'h100; d_write = 1; d_size = 3'd2; d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        total++; if ({d_gnt, i_gnt} !== 2'b10) begin $display("FAIL sim_gnt got=%b exp=10", {d_gnt, i_gnt}); bad++; end
        total++; if (haddr !== 32'h100) begin $display("FAIL sim_haddr got=%h exp=100", haddr); bad++; end
        total++; if (hwrite !== 1'b1 || hprot !== 4'b0011) begin $display("FAIL sim_hwrite_hprot got=%b/%b exp=1/0011", hwrite, hprot); bad++; end
        step(); d_req = 0; d_write = 0; d_wdata = 32'h0;
        @(negedge clk);
        total++; if (hwdata !== 32'hDEADBEEF) begin $display("FAIL sim_hwdata got=%h exp=deadbeef", hwdata); bad++; end
        total++; if (d_rdy !== 1'b1 || d_err !== 1'b0) begin $display("FAIL sim_d_rdy got=%b/%b exp=1/0", d_rdy, d_err); bad++; end
        total++; if (i_gnt !== 1'b1 || haddr !== 32'h200) begin $display("FAIL sim_i_gnt got=%b/%h exp=1/200", i_gnt, haddr); bad++; end
        total++; if (hprot[0] !== 1'b0 || hwrite !== 1'b0) begin $display("FAIL sim_i_hprot got=%b/%b exp=0/0", hprot[0], hwrite); bad++; end
        step(); i_req = 0;
        @(negedge clk);
        total++; if (i_rdy !== 1'b1 || d_rdy !== 1'b0) begin $display("FAIL sim_i_rdy got=%b/%b exp=1/0", i_rdy, d_rdy); bad++; end
        total++; if (hwdata !== 32'hDEADBEEF) begin $display("FAIL sim_hwdata_hold got=%h exp=deadbeef", hwdata); bad++; end
        idle(2);
    endtask

    task automatic test_wait_hold();
        for (int c = 0; c < 3; c++) begin
            step();
            i_req = 1; i_addr = 32'h300; hready = 0;
            if (c >= 1) begin d_req = 1; d_addr = 32'h180; d_write = 0; d_size = 3'd1; end
            @(negedge clk);
            total++; if (haddr !== 32'h300 || htrans !== 2'b10) begin $display("FAIL hold_addr c=%0d got=%h/%h exp=300/2", c, haddr, htrans); bad++; end
            total++; if ({i_gnt, d_gnt} !== 2'b00) begin $display("FAIL hold_gnt c=%0d got=%b exp=00", c, {i_gnt, d_gnt}); bad++; end
        end
        step(); hready = 1;
        @(negedge clk);
        total++; if ({i_gnt, d_gnt} !== 2'b10 || haddr !== 32'h300) begin $display("FAIL hold_release got=%b/%h exp=10/300", {i_gnt, d_gnt}, haddr); bad++; end
        step(); i_req = 0;
        @(negedge clk);
        total++; if (d_gnt !== 1'b1 || haddr !== 32'h180 || hsize !== 3'd1) begin $display("FAIL hold_d_next got=%b/%h/%0d exp=1/180/1", d_gnt, haddr, hsize); bad++; end
        total++; if (i_rdy !== 1'b1) begin $display("FAIL hold_i_rdy got=%b exp=1", i_rdy); bad++; end
        step(); d_req = 0;
        @(negedge clk);
        total++; if (d_rdy !== 1'b1 || i_rdy !== 1'b0) begin $display("FAIL hold_d_rdy got=%b/%b exp=1/0", d_rdy, i_rdy); bad++; end
        idle(2);
    endtask

    task automatic test_read_return();
        step(); i_req = 1; i_addr = 32'h0; hready = 1;
        @(negedge clk);
        total++; if (i_gnt !== 1'b1) begin $display("FAIL rd_gnt got=%b exp=1", i_gnt); bad++; end
        for (int w = 0; w < 2; w++) begin
            step(); i_req = 0; hready = 0;
            @(negedge clk);
            total++; if ({i_rdy, d_rdy} !== 2'b00) begin $display("FAIL rd_wait w=%0d got=%b exp=00", w, {i_rdy, d_rdy}); bad++; end
        end
        step(); hready = 1; hrdata = 32'h00000013;
        @(negedge clk);
        total++; if (i_rdy !== 1'b1 || i_err !== 1'b0 || d_rdy !== 1'b0) begin $display("FAIL rd_rdy got=%b/%b/%b exp=1/0/0", i_rdy, i_err, d_rdy); bad++; end
        total++; if (i_rdata !== 32'h13) begin $display("FAIL rd_data got=%h exp=13", i_rdata); bad++; end
        step(); hrdata = 32'h0;
        @(negedge clk);
        total++; if (i_rdy !== 1'b0) begin $display("FAIL rd_once got=%b exp=0", i_rdy); bad++; end
        idle(2);
    endtask

    task automatic test_error();
        step(); d_req = 1; d_addr = 32'h400; d_write = 0; d_size = 3'd2; hready = 1;
        @(negedge clk);
        total++; if (d_gnt !== 1'b1) begin $display("FAIL err_d_gnt got=%b exp=1", d_gnt); bad++; end
        step(); d_req = 0; i_req = 1; i_addr = 32'h500; hready = 0; hresp = 1;
        @(negedge clk);
        total++; if (htrans !== 2'b00 || i_gnt !== 1'b0) begin $display("FAIL err_idle got=%h/%b exp=0/0", htrans, i_gnt); bad++; end
        total++; if (d_rdy !== 1'b0) begin $display("FAIL err_first_rdy got=%b exp=0", d_rdy); bad++; end
        step(); hready = 1; hresp = 1;
        @(negedge clk);
        total++; if ({d_rdy, d_err} !== 2'b11 || i_rdy !== 1'b0) begin $display("FAIL err_second got=%b/%b exp=11/0", {d_rdy, d_err}, i_rdy); bad++; end
        total++; if (i_gnt !== 1'b1 || haddr !== 32'h500) begin $display("FAIL err_i_gnt got=%b/%h exp=1/500", i_gnt, haddr); bad++; end
        step(); i_req = 0; hresp = 0;
        @(negedge clk);
        total++; if (i_rdy !== 1'b1 || i_err !== 1'b0) begin $display("FAIL err_i_rdy got=%b/%b exp=1/0", i_rdy, i_err); bad++; end
        idle(2);
    endtask

    task automatic test_starve();
        step();
        d_req = 1; d_addr = 32'h600; d_write = 0; d_size = 3'd2;
        i_req = 1; i_addr = 32'h700; hready = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 8) begin
                total++; if ({d_gnt, i_gnt} !== 2'b01 || haddr !== 32'h700) begin $display("FAIL starve_force c=%0d got=%b/%h exp=01/700", c, {d_gnt, i_gnt}, haddr); bad++; end
            end else begin
                total++; if ({d_gnt, i_gnt} !== 2'b10) begin $display("FAIL starve_d c=%0d got=%b exp=10", c, {d_gnt, i_gnt}); bad++; end
            end
            if (c == 9) begin
                total++; if (dut.starve_cnt_q !== 4'd0) begin $display("FAIL starve_cnt got=%0d exp=0", dut.starve_cnt_q); bad++; end
            end
            step();
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_wait_hold();
        test_read_return();
        test_error();
        test_starve();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
